fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Bundle between the fetch unit and the rest of the pipeline: redirect
// requests and trap inputs toward fetch, fetch address and trap report back.
interface fetch_unit_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        jr;
  logic [31:0] jr_target;
  logic        exception;
  logic        irq;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        IF_ID_flush;
  logic [31:0] epc;
  logic        epc_we;
  logic [1:0]  cause;
  logic        kernel_mode;

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target,
           jr, jr_target, exception, irq,
    input  pc, pc_plus4, IF_ID_flush, epc, epc_we, cause, kernel_mode
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target,
           jr, jr_target, exception, irq,
    output pc, pc_plus4, IF_ID_flush, epc, epc_we, cause, kernel_mode
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch PC sequencer: prioritised redirects, trap entry with
// EPC/cause reporting and a latched, deferrable interrupt request.
module fetch_unit (
  input logic        clk,
  input logic        reset,
  fetch_unit_if.slave bus
);

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] EXC_VEC  = 32'h8000_0004;
  localparam logic [31:0] IRQ_VEC  = 32'h8000_0008;

  typedef enum logic [2:0] {
    SRC_BRANCH = 3'd0,
    SRC_EXC    = 3'd1,
    SRC_IRQ    = 3'd2,
    SRC_JR     = 3'd3,
    SRC_JUMP   = 3'd4,
    SRC_HOLD   = 3'd5,
    SRC_SEQ    = 3'd6
  } src_e;

  logic [31:0] r_pc;
  logic [1:0]  r_cause;
  logic        r_irq_pending;

  src_e        w_src;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;
  logic [31:0] w_epc;
  logic        w_flush;
  logic        w_epc_we;
  logic [1:0]  w_cause_next;
  logic        w_pend_clr;
  logic        w_irq_take;
  logic        w_unused;

  // The kernel bit is sticky across sequential fetch; only the low 31 bits wrap.
  assign w_pc_plus4 = {r_pc[31], r_pc[30:0] + 31'd4};
  assign w_irq_take = r_irq_pending & ~r_pc[31] & ~bus.stall;
  assign w_unused   = &{1'b0, bus.branch_target[31], bus.jump_target[31]};

  // Redirect source selection in fixed priority order.
  always_comb begin
    w_src = SRC_SEQ;
    if (bus.branch_taken) begin
      w_src = SRC_BRANCH;
    end else if (bus.exception) begin
      w_src = SRC_EXC;
    end else if (w_irq_take) begin
      w_src = SRC_IRQ;
    end else if (bus.jr) begin
      w_src = SRC_JR;
    end else if (bus.jump) begin
      w_src = SRC_JUMP;
    end else if (bus.stall) begin
      w_src = SRC_HOLD;
    end else begin
      w_src = SRC_SEQ;
    end
  end

  // Next-PC, flush and trap-report decode for the selected source.
  always_comb begin
    w_pc_next    = w_pc_plus4;
    w_flush      = 1'b0;
    w_epc_we     = 1'b0;
    w_epc        = w_pc_plus4;
    w_cause_next = r_cause;
    w_pend_clr   = 1'b0;
    case (w_src)
      SRC_BRANCH: begin
        w_pc_next = {r_pc[31], bus.branch_target[30:0]};
        w_flush   = 1'b1;
      end
      SRC_EXC: begin
        w_pc_next    = EXC_VEC;
        w_flush      = 1'b1;
        w_epc_we     = 1'b1;
        w_epc        = w_pc_plus4;
        w_cause_next = 2'b10;
      end
      SRC_IRQ: begin
        // Interrupted instruction has not executed yet, so it is the return point.
        w_pc_next    = IRQ_VEC;
        w_flush      = 1'b1;
        w_epc_we     = 1'b1;
        w_epc        = r_pc;
        w_cause_next = 2'b01;
        w_pend_clr   = 1'b1;
      end
      SRC_JR: begin
        w_pc_next = bus.jr_target;
        w_flush   = 1'b1;
      end
      SRC_JUMP: begin
        w_pc_next = {r_pc[31], bus.jump_target[30:0]};
        w_flush   = 1'b1;
      end
      SRC_HOLD: begin
        w_pc_next = r_pc;
      end
      SRC_SEQ: begin
        w_pc_next = w_pc_plus4;
      end
      default: begin
        w_pc_next = w_pc_plus4;
      end
    endcase
  end

  // PC, trap cause and interrupt latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc          <= RESET_PC;
      r_cause       <= 2'b00;
      r_irq_pending <= 1'b0;
    end else begin
      r_pc          <= w_pc_next;
      r_cause       <= w_cause_next;
      r_irq_pending <= w_pend_clr ? 1'b0 : (r_irq_pending | bus.irq);
    end
  end

  assign bus.pc          = r_pc;
  assign bus.pc_plus4    = w_pc_plus4;
  assign bus.IF_ID_flush = w_flush & reset;
  assign bus.epc_we      = w_epc_we & reset;
  assign bus.epc         = w_epc;
  assign bus.cause       = r_cause;
  assign bus.kernel_mode = r_pc[31];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a priority-list reference model checked on
// every falling edge, plus literal expectations at key points.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] m_pc;
  logic [1:0]  m_cause;
  logic        m_pend;
  int          m_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] seq_of(input logic [31:0] a);
    return ((a + 32'd4) & 32'h7FFF_FFFF) | (a & 32'h8000_0000);
  endfunction

  // Index into the request list: 0 branch,1 exc,2 irq,3 jr,4 jump,5 stall,6 seq.
  function automatic int pick(input logic bt, input logic ex, input logic jr,
                              input logic jp, input logic st,
                              input logic [31:0] pc, input logic pend);
    logic [6:0] req;
    req = {1'b1, st, jp, jr, pend & !pc[31] & !st, ex, bt};
    for (int i = 0; i < 7; i++) begin
      if (req[i]) return i;
    end
    return 6;
  endfunction

  function automatic logic [31:0] target(input int idx, input logic [31:0] pc);
    case (idx)
      0:       return (pc & 32'h8000_0000) | (bus.branch_target & 32'h7FFF_FFFF);
      1:       return 32'h8000_0004;
      2:       return 32'h8000_0008;
      3:       return bus.jr_target;
      4:       return (pc & 32'h8000_0000) | (bus.jump_target & 32'h7FFF_FFFF);
      5:       return pc;
      default: return seq_of(pc);
    endcase
  endfunction

  assign m_idx = pick(bus.branch_taken, bus.exception, bus.jr, bus.jump, bus.stall, m_pc, m_pend);

  // Reference model state update.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc    <= 32'h8000_0000;
      m_cause <= 2'b00;
      m_pend  <= 1'b0;
    end else begin
      m_pc <= target(m_idx, m_pc);
      if (m_idx == 1) m_cause <= 2'b10;
      else if (m_idx == 2) m_cause <= 2'b01;
      m_pend <= (m_idx == 2) ? 1'b0 : (m_pend | bus.irq);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_pc", bus.pc, 32'h8000_0000);
      chk("rst_flush", {31'd0, bus.IF_ID_flush}, 32'd0);
      chk("rst_epc_we", {31'd0, bus.epc_we}, 32'd0);
      chk("rst_cause", {30'd0, bus.cause}, 32'd0);
    end else begin
      chk("pc", bus.pc, m_pc);
      chk("pc_plus4", bus.pc_plus4, seq_of(m_pc));
      chk("flush", {31'd0, bus.IF_ID_flush}, {31'd0, m_idx < 5});
      chk("epc_we", {31'd0, bus.epc_we}, {31'd0, m_idx == 1 || m_idx == 2});
      if (m_idx == 1) chk("epc_exc", bus.epc, seq_of(m_pc));
      else if (m_idx == 2) chk("epc_irq", bus.epc, m_pc);
      chk("cause", {30'd0, bus.cause}, {30'd0, m_cause});
      chk("kernel", {31'd0, bus.kernel_mode}, {31'd0, m_pc[31]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 32'd0;
    bus.jump = 1'b0; bus.jump_target = 32'd0; bus.jr = 1'b0; bus.jr_target = 32'd0;
    bus.exception = 1'b0; bus.irq = 1'b0;
    #1 reset = 1'b0;
    #1 chk("lit_rst_pc", bus.pc, 32'h8000_0000);
    tick(); tick();
    reset = 1'b1;
    mid(); chk("lit_boot0", bus.pc, 32'h8000_0000);
    tick(); mid(); chk("lit_boot1", bus.pc, 32'h8000_0004);
    tick(); mid(); chk("lit_boot2", bus.pc, 32'h8000_0008);
    tick(); mid(); chk("lit_boot3", bus.pc, 32'h8000_000C);
    chk("lit_boot_flush", {31'd0, bus.IF_ID_flush}, 32'd0);

    tick(); bus.jr = 1'b1; bus.jr_target = 32'h0040_0000;
    mid(); chk("lit_jr_flush", {31'd0, bus.IF_ID_flush}, 32'd1);
    tick(); bus.jr = 1'b0;
    mid(); chk("lit_jr_pc", bus.pc, 32'h0040_0000);
    chk("lit_jr_kernel", {31'd0, bus.kernel_mode}, 32'd0);
    chk("lit_jr_flush_off", {31'd0, bus.IF_ID_flush}, 32'd0);

    bus.jr = 1'b1; bus.jr_target = 32'h0040_0010;
    tick(); bus.jr = 1'b0; bus.stall = 1'b1; bus.irq = 1'b1;
    tick(); bus.irq = 1'b0;
    mid(); chk("lit_stall_pc", bus.pc, 32'h0040_0010);
    chk("lit_stall_no_take", {31'd0, bus.epc_we}, 32'd0);
    tick(); bus.stall = 1'b0;
    mid(); chk("lit_irq_we", {31'd0, bus.epc_we}, 32'd1);
    chk("lit_irq_epc", bus.epc, 32'h0040_0010);
    tick(); mid(); chk("lit_irq_pc", bus.pc, 32'h8000_0008);
    chk("lit_irq_cause", {30'd0, bus.cause}, 32'd1);

    bus.jr = 1'b1; bus.jr_target = 32'h0040_0020;
    tick(); bus.jr = 1'b0;
    bus.branch_taken = 1'b1; bus.branch_target = 32'h0040_0100; bus.exception = 1'b1;
    mid(); chk("lit_br_exc_we", {31'd0, bus.epc_we}, 32'd0);
    tick(); bus.branch_taken = 1'b0;
    mid(); chk("lit_br_pc", bus.pc, 32'h0040_0100);
    chk("lit_br_cause", {30'd0, bus.cause}, 32'd1);
    chk("lit_exc_epc", bus.epc, 32'h0040_0104);
    tick(); bus.exception = 1'b0;
    mid(); chk("lit_exc_pc", bus.pc, 32'h8000_0004);
    chk("lit_exc_cause", {30'd0, bus.cause}, 32'd2);

    bus.irq = 1'b1;
    tick(); bus.irq = 1'b0;
    mid(); chk("lit_kirq_defer", {31'd0, bus.epc_we}, 32'd0);
    tick(); bus.jr = 1'b1; bus.jr_target = 32'h0040_0200;
    tick(); bus.jr = 1'b0;
    mid(); chk("lit_kirq_epc", bus.epc, 32'h0040_0200);
    tick(); mid(); chk("lit_kirq_pc", bus.pc, 32'h8000_0008);

    bus.jr = 1'b1; bus.jr_target = 32'h7FFF_FFFC;
    tick(); bus.jr = 1'b0;
    mid(); chk("lit_wrap_p4", bus.pc_plus4, 32'h0000_0000);
    tick(); mid(); chk("lit_wrap_pc", bus.pc, 32'h0000_0000);
    bus.jr = 1'b1; bus.jr_target = 32'hFFFF_FFFC;
    tick(); bus.jr = 1'b0;
    tick(); mid(); chk("lit_kwrap_pc", bus.pc, 32'h8000_0000);

    bus.jump = 1'b1; bus.jump_target = 32'h0000_1000;
    tick(); bus.jump = 1'b0;
    mid(); chk("lit_jump_pc", bus.pc, 32'h8000_1000);
    bus.stall = 1'b1;
    tick(); bus.stall = 1'b0;
    mid(); chk("lit_hold_pc", bus.pc, 32'h8000_1000);

    tick(); bus.jump = 1'b1; bus.jump_target = 32'h0000_2000;
    #2 reset = 1'b0;
    #1 chk("lit_mrst_pc", bus.pc, 32'h8000_0000);
    chk("lit_mrst_flush", {31'd0, bus.IF_ID_flush}, 32'd0);
    chk("lit_mrst_cause", {30'd0, bus.cause}, 32'd0);
    tick(); bus.jump = 1'b0;
    tick(); reset = 1'b1;
    mid(); chk("lit_post_rst0", bus.pc, 32'h8000_0000);
    tick(); mid(); chk("lit_post_rst1", bus.pc, 32'h8000_0004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
